// File: rtl/life_pkg.sv
// Shared types and constants for the 8x8 Game-of-Life sequencer.
package life_pkg;

    localparam int GRID_N = 8;
    localparam int GRID_W = GRID_N * GRID_N;

    // Bit r*8+c is row r, column c.
    typedef logic [GRID_W-1:0] grid_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/gen_ticker.sv
// Generation tick divider: one-cycle tick every TICK_DIV enabled cycles.
// The count holds while enable is low, so a paused run resumes mid-period.
module gen_ticker #(
    parameter int unsigned TICK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Divider counter: clear has priority, wraps to 0 on the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/life_sequencer.sv
// Run controller for the 8x8 Game-of-Life engine: owns the generation register,
// commits grid_next on ticks or single steps, and halts on extinction/still-life.
// Optional build macro LIFE_OSC2_DETECT_EN adds period-2 oscillator detection.
module life_sequencer
    import life_pkg::*;
#(
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned GEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_seed,
    input  logic [63:0]      seed,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic [63:0]      grid_next,
    output logic [63:0]      grid,
    output logic [GEN_W-1:0] gen_count,
    output logic [2:0]       state,
    output logic             running,
    output logic             extinct,
    output logic             stable,
    output logic             osc2
);

    state_t           state_q, state_d;
    grid_t            grid_q, grid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             running_q;
    logic             ext_q, ext_d;
    logic             stab_q, stab_d;
    logic             tick;
    logic             tick_en;
    logic             commit_opp;
`ifdef LIFE_OSC2_DETECT_EN
    grid_t            prev_q, prev_d;
    logic             osc_q, osc_d;
`endif

    // A pause in the tick cycle suppresses the tick and holds the count.
    assign tick_en = (state_q == RUN) && !pause && !load_seed;

    gen_ticker #(
        .TICK_DIV (TICK_DIV)
    ) u_ticker (
        .clk    (clk),
        .reset  (reset),
        .enable (tick_en),
        .clear  (state_q == LOAD),
        .tick   (tick)
    );

    // Next-state, grid commit and halt detection.
    always_comb begin
        state_d    = state_q;
        grid_d     = grid_q;
        gen_d      = gen_q;
        ext_d      = ext_q;
        stab_d     = stab_q;
        commit_opp = 1'b0;
`ifdef LIFE_OSC2_DETECT_EN
        prev_d     = prev_q;
        osc_d      = osc_q;
`endif
        unique case (state_q)
            IDLE:   if (start) state_d = RUN;
            LOAD: begin
                grid_d = seed;
                gen_d  = '0;
                ext_d  = 1'b0;
                stab_d = 1'b0;
`ifdef LIFE_OSC2_DETECT_EN
                prev_d = '0;
                osc_d  = 1'b0;
`endif
                state_d = PAUSED;
            end
            RUN: begin
                if (pause)     state_d = PAUSED;
                else if (tick) commit_opp = 1'b1;
            end
            PAUSED: begin
                if (start)     state_d = RUN;
                else if (step) commit_opp = 1'b1;
            end
            HALT:   state_d = HALT;
            default: state_d = IDLE;
        endcase

        if (commit_opp && !load_seed) begin
            if (grid_q == '0) begin
                state_d = HALT;
                ext_d   = 1'b1;
            end else if (grid_next == grid_q) begin
                state_d = HALT;
                stab_d  = 1'b1;
`ifdef LIFE_OSC2_DETECT_EN
            end else if ((gen_q != '0) && (grid_next == prev_q)) begin
                state_d = HALT;
                osc_d   = 1'b1;
`endif
            end else begin
                grid_d = grid_next;
                gen_d  = (gen_q == '1) ? gen_q : gen_q + 1'b1;
`ifdef LIFE_OSC2_DETECT_EN
                prev_d = grid_q;
`endif
            end
        end

        if (load_seed) state_d = LOAD;
    end

    // State and datapath registers; running is registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grid_q    <= '0;
            gen_q     <= '0;
            running_q <= 1'b0;
            ext_q     <= 1'b0;
            stab_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_q     <= gen_d;
            running_q <= (state_d == RUN);
            ext_q     <= ext_d;
            stab_q    <= stab_d;
        end
    end

`ifdef LIFE_OSC2_DETECT_EN
    // Previous generation and oscillator flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            osc_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            osc_q  <= osc_d;
        end
    end

    assign osc2 = osc_q;
`else
    assign osc2 = 1'b0;
`endif

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign state     = state_q;
    assign running   = running_q;
    assign extinct   = ext_q;
    assign stable    = stab_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer; a behavioural Life rule supplies grid_next.
// Define LIFE_OSC2_DETECT_EN to exercise the oscillator-halt build.
module tb_life_sequencer;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_seed = 1'b0;
    logic [63:0] seed = '0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        step = 1'b0;
    logic [63:0] grid_next;
    logic [63:0] grid;
    logic [15:0] gen_count;
    logic [2:0]  state;
    logic        running, extinct, stable, osc2;

    int n_checks = 0;
    int n_pass   = 0;

    life_sequencer #(
        .TICK_DIV (8),
        .GEN_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_seed (load_seed),
        .seed      (seed),
        .start     (start),
        .pause     (pause),
        .step      (step),
        .grid_next (grid_next),
        .grid      (grid),
        .gen_count (gen_count),
        .state     (state),
        .running   (running),
        .extinct   (extinct),
        .stable    (stable),
        .osc2      (osc2)
    );

    always #5 clk = ~clk;

    // Conway rule, no wrap-around at the edges.
    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < 8) &&
                            (c + dc >= 0) && (c + dc < 8) && g[(r + dr) * 8 + c + dc])
                            cnt++;
                    end
                end
                n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    always_comb grid_next = life_step(grid);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_grid(input logic [63:0] v);
        seed      = v;
        load_seed = 1'b1;
        tick_clk(1);
        check_eq("load_state", 64'(state), 64'd1);
        load_seed = 1'b0;
        tick_clk(1);
        check_eq("load_paused", 64'(state), 64'd3);
        check_eq("load_grid", grid, v);
        check_eq("load_gen", 64'(gen_count), 64'd0);
        check_eq("load_flags", {61'd0, extinct, stable, osc2}, 64'd0);
    endtask

    initial begin
        tick_clk(2);
        check_eq("rst_grid", grid, 64'd0);
        check_eq("rst_gen", 64'(gen_count), 64'd0);
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_flags", {60'd0, running, extinct, stable, osc2}, 64'd0);
        reset = 1'b0;
        step  = 1'b1;
        pause = 1'b1;
        tick_clk(1);
        check_eq("idle_ignores_step", 64'(state), 64'd0);
        step  = 1'b0;
        pause = 1'b0;

        // Blinker: first commit 8 edges after entering RUN.
        load_grid(BLINK_H);
        start = 1'b1;
        tick_clk(1);
        start = 1'b0;
        check_eq("run_entry", 64'(running), 64'd1);
        tick_clk(7);
        check_eq("pre_tick_grid", grid, BLINK_H);
        tick_clk(1);
        check_eq("tick1_grid", grid, BLINK_V);
        check_eq("tick1_gen", 64'(gen_count), 64'd1);
        tick_clk(8);
`ifdef LIFE_OSC2_DETECT_EN
        check_eq("osc_state", 64'(state), 64'd4);
        check_eq("osc_flag", 64'(osc2), 64'd1);
        check_eq("osc_gen", 64'(gen_count), 64'd1);
        check_eq("osc_grid", grid, BLINK_V);
        load_grid(BLINK_H);
        start = 1'b1;
        tick_clk(1);
        start = 1'b0;
        tick_clk(3);
        check_eq("osc_rerun", {62'd0, running, osc2}, 64'd2);
`else
        check_eq("tick2_grid", grid, BLINK_H);
        check_eq("tick2_gen", 64'(gen_count), 64'd2);
        check_eq("tick2_osc", 64'(osc2), 64'd0);
        // Pause exactly on the tick cycle.
        tick_clk(7);
        pause = 1'b1;
        tick_clk(1);
        pause = 1'b0;
        check_eq("pause_state", 64'(state), 64'd3);
        check_eq("pause_no_commit", 64'(gen_count), 64'd2);
        check_eq("pause_grid", grid, BLINK_H);
        step = 1'b1;
        tick_clk(1);
        check_eq("step1_gen", 64'(gen_count), 64'd3);
        tick_clk(1);
        check_eq("step2_gen", 64'(gen_count), 64'd4);
        check_eq("step2_grid", grid, BLINK_H);
        check_eq("step_stays", 64'(state), 64'd3);
        start = 1'b1;
        tick_clk(1);
        start = 1'b0;
        step  = 1'b0;
        check_eq("start_wins_state", 64'(state), 64'd2);
        check_eq("start_wins_gen", 64'(gen_count), 64'd4);
        // Held count was at the tick, so resume commits immediately.
        tick_clk(1);
        check_eq("resume_gen", 64'(gen_count), 64'd5);
        check_eq("resume_grid", grid, BLINK_V);
`endif

        // Asynchronous reset mid-run.
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_grid", grid, 64'd0);
        check_eq("async_rst_gen", 64'(gen_count), 64'd0);
        check_eq("async_rst_state", {59'd0, state, running, osc2}, 64'd0);
        tick_clk(1);
        reset = 1'b0;

        // Block is a still life.
        load_grid(BLOCK);
        start = 1'b1;
        tick_clk(1);
        start = 1'b0;
        tick_clk(7);
        check_eq("block_running", 64'(running), 64'd1);
        tick_clk(1);
        check_eq("block_halt", 64'(state), 64'd4);
        check_eq("block_stable", {62'd0, extinct, stable}, 64'd1);
        check_eq("block_gen", 64'(gen_count), 64'd0);
        check_eq("block_grid", grid, BLOCK);
        check_eq("block_not_running", 64'(running), 64'd0);

        // Empty grid halts as extinct; load clears the stable flag.
        load_grid(64'd0);
        step = 1'b1;
        tick_clk(1);
        step = 1'b0;
        check_eq("ext_halt", 64'(state), 64'd4);
        check_eq("ext_flags", {62'd0, extinct, stable}, 64'd2);
        start = 1'b1;
        step  = 1'b1;
        tick_clk(2);
        start = 1'b0;
        step  = 1'b0;
        check_eq("halt_holds", 64'(state), 64'd4);
        check_eq("halt_flag_holds", 64'(extinct), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
